// File: rtl/ro_pair_counter.sv
// Ring-oscillator PUF pair counter: selects two ROs, settles, counts edges
// over a fixed gate window and compares the two counts into one response bit.
module ro_pair_counter #(
    parameter int COUNT_WIDTH   = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   Start,
    input  logic [7:0]             Challenge,
    input  logic                   Ro_A,
    input  logic                   Ro_B,
    output logic [4:0]             Sel_A,
    output logic [4:0]             Sel_B,
    output logic                   Ro_Enable,
    output logic                   Busy,
    output logic                   Valid,
    output logic                   Response,
    output logic                   Tie,
    output logic [COUNT_WIDTH-1:0] Count_A,
    output logic [COUNT_WIDTH-1:0] Count_B
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COUNT,
        COMPARE,
        DONE
    } state_t;

    localparam int MAXC = (WINDOW_CYCLES > SETTLE_CYCLES) ?
                          WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WINDOW_LD = TW'(WINDOW_CYCLES - 1);

    state_t state;
    state_t state_nx;

    logic [TW-1:0]          timer;
    logic [1:0]             sync_a;
    logic [1:0]             sync_b;
    logic                   prev_a;
    logic                   prev_b;
    logic                   edge_a;
    logic                   edge_b;
    logic [COUNT_WIDTH-1:0] cnt_a;
    logic [COUNT_WIDTH-1:0] cnt_b;
    logic                   accept;
    logic                   same_sel;
    logic                   timer_done;

    assign accept     = (state == IDLE) && Start;
    assign same_sel   = (Challenge[3:0] == Challenge[7:4]);
    assign timer_done = (timer == '0);
    assign edge_a     = sync_a[1] & ~prev_a;
    assign edge_b     = sync_b[1] & ~prev_b;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        Ro_Enable = 1'b0;
        Busy      = 1'b1;
        Valid     = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    state_nx = same_sel ? DONE : SETTLE;
                end
            end
            SETTLE: begin
                Ro_Enable = 1'b1;
                if (timer_done) begin
                    state_nx = COUNT;
                end
            end
            COUNT: begin
                Ro_Enable = 1'b1;
                if (timer_done) begin
                    state_nx = COMPARE;
                end
            end
            COMPARE: begin
                state_nx = DONE;
            end
            DONE: begin
                Valid    = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Ro inputs are asynchronous: two-flop sync, then a history flop for edges.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
            prev_a <= 1'b0;
            prev_b <= 1'b0;
        end else begin
            sync_a <= {sync_a[0], Ro_A};
            sync_b <= {sync_b[0], Ro_B};
            prev_a <= sync_a[1];
            prev_b <= sync_b[1];
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            timer <= '0;
        end else if (accept) begin
            timer <= SETTLE_LD;
        end else if (state == SETTLE && timer_done) begin
            timer <= WINDOW_LD;
        end else if (!timer_done) begin
            timer <= timer - TW'(1);
        end
    end

    // Edge counters saturate rather than wrap.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (accept) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (state == COUNT) begin
            if (edge_a && cnt_a != '1) begin
                cnt_a <= cnt_a + COUNT_WIDTH'(1);
            end
            if (edge_b && cnt_b != '1) begin
                cnt_b <= cnt_b + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Sel_A    <= '0;
            Sel_B    <= '0;
            Response <= 1'b0;
            Tie      <= 1'b0;
            Count_A  <= '0;
            Count_B  <= '0;
        end else if (accept) begin
            Sel_A    <= {1'b0, Challenge[3:0]};
            Sel_B    <= {1'b0, Challenge[7:4]};
            Response <= 1'b0;
            Tie      <= same_sel;
            Count_A  <= '0;
            Count_B  <= '0;
        end else if (state == COMPARE) begin
            Response <= (cnt_a > cnt_b);
            Tie      <= (cnt_a == cnt_b) || (Sel_A == Sel_B);
            Count_A  <= cnt_a;
            Count_B  <= cnt_b;
        end
    end

endmodule
